// File: rtl/pvt_meas_pkg.sv
// Shared types and constants for the PVT measurement statistics block.
package pvt_meas_pkg;
  localparam int MEAS_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } stats_state_e;

  localparam logic [1:0] SEL_MIN  = 2'd0;
  localparam logic [1:0] SEL_MAX  = 2'd1;
  localparam logic [1:0] SEL_MEAN = 2'd2;
  localparam logic [1:0] SEL_LAST = 2'd3;

  typedef logic [MEAS_W-1:0] meas_cnt_t;
endpackage

// File: rtl/pvt_meas_stats_if.sv
// Control, measurement and readback signals of pvt_meas_stats.
// Handshake: run is a level request sampled in IDLE/DONE; done stays high until the next run/abort.
interface pvt_meas_stats_if #(
  parameter int W = 8
) ();
  logic         run;
  logic         abort;
  logic [W-1:0] meas_cnt;
  logic         meas_start;
  logic         busy;
  logic         done;
  logic [1:0]   sel;
  logic [W-1:0] result;

  modport master (
    output run, abort, meas_cnt, sel,
    input  meas_start, busy, done, result
  );

  modport slave (
    input  run, abort, meas_cnt, sel,
    output meas_start, busy, done, result
  );
endinterface

// File: rtl/pvt_meas_accum.sv
// Min/max/sum/last datapath; working values update on capture, readback copies on commit.
module pvt_meas_accum
  import pvt_meas_pkg::*;
#(
  parameter int LOG2_N = 4,
  parameter int W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         capture,
  input  logic         commit,
  input  logic [W-1:0] sample,
  output logic [W-1:0] lat_min,
  output logic [W-1:0] lat_max,
  output logic [W-1:0] lat_mean,
  output logic [W-1:0] lat_last
);
  localparam int SUMW = W + LOG2_N;

  logic [W-1:0]    work_min, work_max;
  logic [SUMW-1:0] work_sum;
  logic [W-1:0]    nxt_min, nxt_max;
  logic [SUMW-1:0] nxt_sum;

  // Commit uses the values including the final sample, so it works off the next-state terms.
  always_comb begin
    nxt_min = (sample < work_min) ? sample : work_min;
    nxt_max = (sample > work_max) ? sample : work_max;
    nxt_sum = work_sum + SUMW'(sample);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_min <= '0;
      work_max <= '0;
      work_sum <= '0;
    end else if (init) begin
      work_min <= '1;
      work_max <= '0;
      work_sum <= '0;
    end else if (capture) begin
      work_min <= nxt_min;
      work_max <= nxt_max;
      work_sum <= nxt_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_min  <= '0;
      lat_max  <= '0;
      lat_mean <= '0;
      lat_last <= '0;
    end else if (commit) begin
      lat_min  <= nxt_min;
      lat_max  <= nxt_max;
      lat_mean <= nxt_sum[SUMW-1:LOG2_N];
      lat_last <= sample;
    end
  end
endmodule

// File: rtl/pvt_meas_stats.sv
// Sequences N settle-and-capture measurements and exposes min/max/mean/last through a select mux.
module pvt_meas_stats
  import pvt_meas_pkg::*;
#(
  parameter int LOG2_N        = 4,
  parameter int SETTLE_CYCLES = 32,
  parameter int W             = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pvt_meas_stats_if.slave        bus,
  output logic [2:0]             dbg_state
);
  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_START   = START;
  localparam logic [2:0] ST_WAIT    = WAIT;
  localparam logic [2:0] ST_CAPTURE = CAPTURE;
  localparam logic [2:0] ST_DONE    = DONE;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic [2:0]        state, state_nxt;
  logic [SW-1:0]     settle_cnt;
  logic [LOG2_N-1:0] idx;
  logic              last_sample;
  logic              init_stb, capture_stb, commit_stb;
  logic [W-1:0]      lat_min, lat_max, lat_mean, lat_last;

  assign last_sample = &idx;
  assign init_stb    = ((state == ST_IDLE) || (state == ST_DONE)) && bus.run && !bus.abort;
  // An abort in CAPTURE discards the sample and must not commit.
  assign capture_stb = (state == ST_CAPTURE) && !bus.abort;
  assign commit_stb  = capture_stb && last_sample;

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (bus.run) state_nxt = ST_START;
        ST_START:         state_nxt = ST_WAIT;
        ST_WAIT:          if (settle_cnt == SETTLE_LAST) state_nxt = ST_CAPTURE;
        ST_CAPTURE:       state_nxt = last_sample ? ST_DONE : ST_START;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      idx        <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT) settle_cnt <= settle_cnt + 1'b1;
      else                  settle_cnt <= '0;
      if (init_stb)                         idx <= '0;
      else if (capture_stb && !last_sample) idx <= idx + 1'b1;
    end
  end

  assign bus.meas_start = (state == ST_START);
  assign bus.busy       = (state == ST_START) || (state == ST_WAIT) || (state == ST_CAPTURE);
  assign bus.done       = (state == ST_DONE);
  assign dbg_state      = state;

  pvt_meas_accum #(
    .LOG2_N (LOG2_N),
    .W      (W)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .init     (init_stb),
    .capture  (capture_stb),
    .commit   (commit_stb),
    .sample   (bus.meas_cnt),
    .lat_min  (lat_min),
    .lat_max  (lat_max),
    .lat_mean (lat_mean),
    .lat_last (lat_last)
  );

  always_comb begin
    bus.result = lat_min;
    case (bus.sel)
      SEL_MIN:  bus.result = lat_min;
      SEL_MAX:  bus.result = lat_max;
      SEL_MEAN: bus.result = lat_mean;
      SEL_LAST: bus.result = lat_last;
      default:  bus.result = lat_min;
    endcase
  end
endmodule
